// File: rtl/beep_pkg.sv
// Shared FSM state encoding, 50 MHz default timing and counter sizing helper
// for the beep pattern generator.
package beep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_GAP  = 2'd2
    } beep_state_e;

    localparam int DEF_HALF_PERIOD = 12_500;     // 2 kHz tone at 50 MHz
    localparam int DEF_ON_CYCLES   = 5_000_000;  // 100 ms burst
    localparam int DEF_OFF_CYCLES  = 5_000_000;  // 100 ms gap

    // A terminal count of 1 still needs one counter bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tone_div.sv
// Square-wave divider: toggles every HALF_PERIOD enabled cycles, forced high on
// restart and held low (counter cleared) while disabled.
module tone_div
    import beep_pkg::*;
#(
    parameter int HALF_PERIOD = DEF_HALF_PERIOD
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic restart_i,
    output logic tone_o
);

    localparam int CW = cnt_width(HALF_PERIOD);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tone_q, tone_d;

    // Next-state for the half-period counter and tone level
    always_comb begin
        cnt_d  = cnt_q;
        tone_d = tone_q;
        if (restart_i) begin
            cnt_d  = '0;
            tone_d = 1'b1;
        end else if (en_i) begin
            if (cnt_q == CW'(HALF_PERIOD - 1)) begin
                cnt_d  = '0;
                tone_d = ~tone_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            cnt_d  = '0;
            tone_d = 1'b0;
        end
    end

    // Divider registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            tone_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tone_q <= tone_d;
        end
    end

    assign tone_o = tone_q;

endmodule

// File: rtl/beep_pattern_gen.sv
// Plays beep_num tone bursts separated by silent gaps; stop or reset aborts
// without a done pulse. All outputs come straight from flops.
module beep_pattern_gen
    import beep_pkg::*;
#(
    parameter int HALF_PERIOD = DEF_HALF_PERIOD,
    parameter int ON_CYCLES   = DEF_ON_CYCLES,
    parameter int OFF_CYCLES  = DEF_OFF_CYCLES
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       req,
    input  logic [3:0] beep_num,
    input  logic       stop,
    output logic       beep,
    output logic       busy,
    output logic       done
);

    localparam int ON_W  = cnt_width(ON_CYCLES);
    localparam int GAP_W = cnt_width(OFF_CYCLES);

    beep_state_e      state_q, state_d;
    logic [ON_W-1:0]  on_cnt_q, on_cnt_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [3:0]       rem_q, rem_d;
    logic             busy_q, done_q, done_d;
    logic             tone_en_s, tone_restart_s, tone_s;

    // Next-state, burst/gap counting and completion detection
    always_comb begin
        state_d   = state_q;
        on_cnt_d  = on_cnt_q;
        gap_cnt_d = gap_cnt_q;
        rem_d     = rem_q;
        done_d    = 1'b0;
        if (stop) begin
            state_d   = ST_IDLE;
            on_cnt_d  = '0;
            gap_cnt_d = '0;
            rem_d     = 4'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req && (beep_num != 4'd0)) begin
                        state_d  = ST_ON;
                        rem_d    = beep_num;
                        on_cnt_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_ON: begin
                    if (on_cnt_q == ON_W'(ON_CYCLES - 1)) begin
                        on_cnt_d = '0;
                        rem_d    = rem_q - 4'd1;
                        // Last burst returns straight to IDLE, no trailing gap.
                        if (rem_q == 4'd1) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_GAP;
                        end
                    end else begin
                        on_cnt_d = on_cnt_q + ON_W'(1);
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q == GAP_W'(OFF_CYCLES - 1)) begin
                        gap_cnt_d = '0;
                        state_d   = ST_ON;
                    end else begin
                        gap_cnt_d = gap_cnt_q + GAP_W'(1);
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    on_cnt_d  = '0;
                    gap_cnt_d = '0;
                    rem_d     = 4'd0;
                end
            endcase
        end
    end

    // Tone runs only in ON and restarts its phase high on every ON entry.
    assign tone_en_s      = (state_d == ST_ON);
    assign tone_restart_s = (state_d == ST_ON) && (state_q != ST_ON);

    // State, counters and registered status outputs
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q   <= ST_IDLE;
            on_cnt_q  <= '0;
            gap_cnt_q <= '0;
            rem_q     <= 4'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            on_cnt_q  <= on_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            rem_q     <= rem_d;
            busy_q    <= (state_d != ST_IDLE);
            done_q    <= done_d;
        end
    end

    tone_div #(
        .HALF_PERIOD(HALF_PERIOD)
    ) u_tone_div (
        .clk_i    (sys_clk),
        .rst_i    (sys_rst),
        .en_i     (tone_en_s),
        .restart_i(tone_restart_s),
        .tone_o   (tone_s)
    );

    assign beep = tone_s;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_beep_pattern_gen.sv
// Directed and random stimulus for beep_pattern_gen, checked cycle by cycle
// against a schedule-based model of the expected beep/busy/done waveform.
module tb_beep_pattern_gen;

    localparam int HP   = 2;
    localparam int ONC  = 8;
    localparam int OFFC = 6;

    typedef struct packed {
        logic beep;
        logic busy;
        logic done;
    } exp_t;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       req = 1'b0;
    logic [3:0] beep_num = 4'd0;
    logic       stop = 1'b0;
    logic       beep, busy, done;

    int    checks = 0;
    int    errors = 0;
    exp_t  sched[$];
    exp_t  cur = '0;
    int    busy_cnt, done_cnt;
    logic [15:0] beep_hist;

    beep_pattern_gen #(
        .HALF_PERIOD(HP),
        .ON_CYCLES  (ONC),
        .OFF_CYCLES (OFFC)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .req     (req),
        .beep_num(beep_num),
        .stop    (stop),
        .beep    (beep),
        .busy    (busy),
        .done    (done)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Whole pattern for n bursts: tone phase from position in burst, zero gaps, then done.
    task automatic build(input int n);
        exp_t e;
        for (int b = 0; b < n; b++) begin
            for (int i = 0; i < ONC; i++) begin
                e.beep = ((i / HP) % 2 == 0);
                e.busy = 1'b1;
                e.done = 1'b0;
                sched.push_back(e);
            end
            if (b < n - 1) begin
                for (int i = 0; i < OFFC; i++) begin
                    e = '0;
                    e.busy = 1'b1;
                    sched.push_back(e);
                end
            end
        end
        e = '0;
        e.done = 1'b1;
        sched.push_back(e);
    endtask

    task automatic step(input logic r, input logic [3:0] n, input logic s, input logic rs);
        req      = r;
        beep_num = n;
        stop     = s;
        sys_rst  = rs;
        if (rs || s) sched.delete();
        else if (r && (n != 4'd0) && !cur.busy) build(int'(n));
        @(posedge sys_clk);
        #1;
        cur = (sched.size() > 0) ? sched.pop_front() : exp_t'(3'b000);
        chk("beep", 32'(beep), 32'(cur.beep));
        chk("busy", 32'(busy), 32'(cur.busy));
        chk("done", 32'(done), 32'(cur.done));
        busy_cnt += int'(busy === 1'b1);
        done_cnt += int'(done === 1'b1);
        if (busy === 1'b1) beep_hist = {beep_hist[14:0], beep};
    endtask

    task automatic clear_stats();
        busy_cnt  = 0;
        done_cnt  = 0;
        beep_hist = 16'h0000;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    initial begin
        clear_stats();
        step(1'b0, 4'd0, 1'b0, 1'b1);
        step(1'b1, 4'd5, 1'b1, 1'b1);
        idle(3);

        // Single burst: tone shape and done one cycle after the burst
        clear_stats();
        step(1'b1, 4'd1, 1'b0, 1'b0);
        idle(10);
        chk("s1_beep_shape", 32'(beep_hist[7:0]), 32'(8'b1100_1100));
        chk("s1_busy_len", busy_cnt, ONC);
        chk("s1_done_cnt", done_cnt, 1);

        // Three bursts
        clear_stats();
        step(1'b1, 4'd3, 1'b0, 1'b0);
        idle(40);
        chk("s2_busy_len", busy_cnt, 3 * ONC + 2 * OFFC);
        chk("s2_done_cnt", done_cnt, 1);

        // Zero count ignored; later req/beep_num changes while busy ignored
        clear_stats();
        step(1'b1, 4'd0, 1'b0, 1'b0);
        idle(2);
        chk("s3_zero_ignored", busy_cnt + done_cnt, 0);
        step(1'b1, 4'd2, 1'b0, 1'b0);
        idle(4);
        step(1'b1, 4'd15, 1'b0, 1'b0);
        step(1'b0, 4'd7, 1'b0, 1'b0);
        idle(30);
        chk("s3_busy_len", busy_cnt, 2 * ONC + OFFC);
        chk("s3_done_cnt", done_cnt, 1);

        // Stop on third cycle of burst 2 of 3
        clear_stats();
        step(1'b1, 4'd3, 1'b0, 1'b0);
        idle(16);
        step(1'b0, 4'd0, 1'b1, 1'b0);
        chk("s4_beep_after_stop", 32'(beep), 32'd0);
        chk("s4_busy_after_stop", 32'(busy), 32'd0);
        idle(30);
        chk("s4_no_done", done_cnt, 0);

        // Reset mid-gap, then a clean single burst
        clear_stats();
        step(1'b1, 4'd2, 1'b0, 1'b0);
        idle(10);
        step(1'b1, 4'd3, 1'b1, 1'b1);
        chk("s5_busy_after_rst", 32'(busy), 32'd0);
        idle(2);
        chk("s5_no_done", done_cnt, 0);
        clear_stats();
        step(1'b1, 4'd1, 1'b0, 1'b0);
        chk("s5_restart_high", 32'(beep), 32'd1);
        idle(10);
        chk("s5_beep_shape", 32'(beep_hist[7:0]), 32'(8'b1100_1100));

        // Req in the done cycle, then req+stop in IDLE
        step(1'b1, 4'd1, 1'b0, 1'b0);
        idle(8);
        chk("s6_done_cycle", 32'(done), 32'd1);
        step(1'b1, 4'd1, 1'b0, 1'b0);
        chk("s6_back_to_back", 32'(busy), 32'd1);
        idle(10);
        clear_stats();
        step(1'b1, 4'd2, 1'b1, 1'b0);
        idle(5);
        chk("s6_req_stop_dropped", busy_cnt, 0);

        // Random traffic against the schedule model
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(7) == 0),
                 4'($urandom_range(15)),
                 ($urandom_range(63) == 0),
                 ($urandom_range(127) == 0));
        end
        idle(60);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
